// File: rtl/fifo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fifo_ctrl_pkg
// Shared constants and types for the synchronous FIFO pointer/flag controller.
//   FIFO_DEPTH   - number of memory entries (power of two)
//   FIFO_ADDR_W  - memory address width, log2(FIFO_DEPTH)
//   FIFO_CNT_W   - occupancy width, able to hold 0..FIFO_DEPTH
//   fifo_ptr_t   - pointer with one extra MSB used as a wrap bit
// -----------------------------------------------------------------------------
package fifo_ctrl_pkg;

  localparam int FIFO_DEPTH  = 16;
  localparam int FIFO_ADDR_W = 4;
  localparam int FIFO_CNT_W  = 5;

  typedef logic [FIFO_ADDR_W:0]  fifo_ptr_t;
  typedef logic [FIFO_CNT_W-1:0] fifo_cnt_t;

endpackage

// File: rtl/fifo_sync_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_sync_ctrl_if
// Bundles the user request/flag signals and the memory control signals of
// fifo_sync_ctrl.
//   slave  modport : the controller (takes requests, drives enables/flags)
//   master modport : the user side (drives requests, observes enables/flags)
// -----------------------------------------------------------------------------
interface fifo_sync_ctrl_if;
  import fifo_ctrl_pkg::*;

  logic                   wr_req_i;
  logic                   rd_req_i;
  logic                   clr_err_i;
  logic                   mem_wr_en_o;
  logic [FIFO_ADDR_W-1:0] mem_wr_ptr_o;
  logic                   mem_rd_en_o;
  logic [FIFO_ADDR_W-1:0] mem_rd_ptr_o;
  logic                   rd_valid_o;
  logic                   full_o;
  logic                   empty_o;
  fifo_cnt_t              count_o;
  logic                   overflow_o;
  logic                   underflow_o;
  logic                   almost_full_o;
  logic                   almost_empty_o;

  modport slave (
    input  wr_req_i, rd_req_i, clr_err_i,
    output mem_wr_en_o, mem_wr_ptr_o, mem_rd_en_o, mem_rd_ptr_o, rd_valid_o,
           full_o, empty_o, count_o, overflow_o, underflow_o,
           almost_full_o, almost_empty_o
  );

  modport master (
    output wr_req_i, rd_req_i, clr_err_i,
    input  mem_wr_en_o, mem_wr_ptr_o, mem_rd_en_o, mem_rd_ptr_o, rd_valid_o,
           full_o, empty_o, count_o, overflow_o, underflow_o,
           almost_full_o, almost_empty_o
  );

endinterface

// File: rtl/fifo_ptr_cnt.sv
// -----------------------------------------------------------------------------
// fifo_ptr_cnt
// Wrap-bit pointer: increments by one when en_i is high, wrapping naturally
// through the extra MSB. Synchronous active-high reset to zero.
//   clk_a  - clock
//   rst_i  - synchronous active-high reset
//   en_i   - advance pointer this cycle
//   ptr_o  - registered pointer (address bits plus wrap bit)
// -----------------------------------------------------------------------------
module fifo_ptr_cnt
  import fifo_ctrl_pkg::*;
(
  input  logic      clk_a,
  input  logic      rst_i,
  input  logic      en_i,
  output fifo_ptr_t ptr_o
);

  fifo_ptr_t ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) ptr_d = ptr_q + fifo_ptr_t'(1);
  end

  always_ff @(posedge clk_a) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_sync_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_sync_ctrl
// Pointer/flag controller for a single-clock FIFO memory. Only control passes
// through here; write and read data go straight between user and memory.
//   clk_a  - single clock
//   rst_i  - synchronous active-high reset
//   bus    - fifo_sync_ctrl_if.slave: requests/clear in; memory enables and
//            addresses, rd_valid, full/empty, count, sticky errors and the
//            almost flags out
// Optional build macro FIFO_ALMOST_FLAGS_EN enables registered almost_full /
// almost_empty flags; without it both outputs are tied low.
// -----------------------------------------------------------------------------
module fifo_sync_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int ADDR_W    = FIFO_ADDR_W
`ifdef FIFO_ALMOST_FLAGS_EN
  ,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2
`endif
)(
  input  logic             clk_a,
  input  logic             rst_i,
  fifo_sync_ctrl_if.slave  bus
);

  localparam fifo_cnt_t DEPTH_C = fifo_cnt_t'(DEPTH);

  // Index 0 is the write pointer, index 1 the read pointer.
  fifo_ptr_t ptr_w  [2];
  logic      ptr_en [2];

  logic      wa, ra;
  fifo_cnt_t count_cur, count_d;
  logic      full_q, full_d, empty_q, empty_d;
  logic      rd_valid_q;
  logic      ovf_q, ovf_d, unf_q, unf_d;

  // Accepts are gated by reset so no memory access escapes while rst_i is high.
  assign wa = bus.wr_req_i & ~full_q  & ~rst_i;
  assign ra = bus.rd_req_i & ~empty_q & ~rst_i;

  assign ptr_en[0] = wa;
  assign ptr_en[1] = ra;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ptr
      fifo_ptr_cnt u_ptr (
        .clk_a (clk_a),
        .rst_i (rst_i),
        .en_i  (ptr_en[gi]),
        .ptr_o (ptr_w[gi])
      );
    end
  endgenerate

  // Occupancy is the wrap-aware pointer difference; the extra MSB makes a
  // full FIFO (same address, different wrap bit) read as DEPTH, not 0.
  assign count_cur = ptr_w[0] - ptr_w[1];

  always_comb begin
    count_d = count_cur;
    unique case ({wa, ra})
      2'b10:   count_d = count_cur + fifo_cnt_t'(1);
      2'b01:   count_d = count_cur - fifo_cnt_t'(1);
      default: count_d = count_cur;
    endcase
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    // Setting wins over a coincident clear.
    ovf_d   = (bus.wr_req_i & full_q)  | (ovf_q & ~bus.clr_err_i);
    unf_d   = (bus.rd_req_i & empty_q) | (unf_q & ~bus.clr_err_i);
  end

  always_ff @(posedge clk_a) begin
    if (rst_i) begin
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      full_q     <= full_d;
      empty_q    <= empty_d;
      rd_valid_q <= ra;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

`ifdef FIFO_ALMOST_FLAGS_EN
  localparam fifo_cnt_t AF_C = fifo_cnt_t'(AF_THRESH);
  localparam fifo_cnt_t AE_C = fifo_cnt_t'(AE_THRESH);

  logic af_q, ae_q;

  always_ff @(posedge clk_a) begin
    if (rst_i) begin
      af_q <= 1'b0;
      ae_q <= 1'b1;
    end else begin
      af_q <= (count_d >= AF_C);
      ae_q <= (count_d <= AE_C);
    end
  end

  assign bus.almost_full_o  = af_q;
  assign bus.almost_empty_o = ae_q;
`else
  assign bus.almost_full_o  = 1'b0;
  assign bus.almost_empty_o = 1'b0;
`endif

  assign bus.mem_wr_en_o  = wa;
  assign bus.mem_rd_en_o  = ra;
  assign bus.mem_wr_ptr_o = ptr_w[0][ADDR_W-1:0];
  assign bus.mem_rd_ptr_o = ptr_w[1][ADDR_W-1:0];
  assign bus.rd_valid_o   = rd_valid_q;
  assign bus.full_o       = full_q;
  assign bus.empty_o      = empty_q;
  assign bus.count_o      = count_cur;
  assign bus.overflow_o   = ovf_q;
  assign bus.underflow_o  = unf_q;

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_sync_ctrl
// Self-checking bench for fifo_sync_ctrl. A queue of written addresses models
// the FIFO contents; occupancy, flags and the expected read address all follow
// from that queue. Directed sequences come first, then biased random traffic.
// -----------------------------------------------------------------------------
module tb_fifo_sync_ctrl;
  import fifo_ctrl_pkg::*;

  logic clk_a = 1'b0;
  logic rst_i;

  always #5 clk_a = ~clk_a;

  fifo_sync_ctrl_if bus ();

  fifo_sync_ctrl dut (
    .clk_a (clk_a),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int q[$];          // addresses currently held, oldest first
  int m_wa  = 0;     // next write address
  bit m_ovf = 0;
  bit m_unf = 0;
  bit m_rv  = 0;
  int n_step = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d (step %0d)", tag, obs, exp, n_step);
    end
  endtask

  task automatic step(input bit wr, input bit rd, input bit clr, input bit rst);
    bit m_full, m_empty, e_wa, e_ra;
    bus.wr_req_i  = wr;
    bus.rd_req_i  = rd;
    bus.clr_err_i = clr;
    rst_i         = rst;
    #1;
    m_full  = (q.size() == FIFO_DEPTH);
    m_empty = (q.size() == 0);
    e_wa    = wr && !m_full  && !rst;
    e_ra    = rd && !m_empty && !rst;
    check_val("mem_wr_en", bus.mem_wr_en_o, e_wa);
    check_val("mem_rd_en", bus.mem_rd_en_o, e_ra);
    if (e_wa) check_val("mem_wr_ptr", bus.mem_wr_ptr_o, m_wa);
    if (e_ra) check_val("mem_rd_ptr", bus.mem_rd_ptr_o, q[0]);

    @(posedge clk_a);
    if (rst) begin
      q.delete();
      m_wa  = 0;
      m_ovf = 0;
      m_unf = 0;
      m_rv  = 0;
    end else begin
      m_ovf = (wr && m_full)  || (m_ovf && !clr);
      m_unf = (rd && m_empty) || (m_unf && !clr);
      m_rv  = e_ra;
      if (e_ra) void'(q.pop_front());
      if (e_wa) begin
        q.push_back(m_wa);
        m_wa = (m_wa + 1) % FIFO_DEPTH;
      end
    end
    #1;
    check_val("count",     bus.count_o,     q.size());
    check_val("full",      bus.full_o,      q.size() == FIFO_DEPTH);
    check_val("empty",     bus.empty_o,     q.size() == 0);
    check_val("rd_valid",  bus.rd_valid_o,  m_rv);
    check_val("overflow",  bus.overflow_o,  m_ovf);
    check_val("underflow", bus.underflow_o, m_unf);
`ifdef FIFO_ALMOST_FLAGS_EN
    check_val("almost_full",  bus.almost_full_o,  q.size() >= 14);
    check_val("almost_empty", bus.almost_empty_o, q.size() <= 2);
`else
    check_val("almost_full",  bus.almost_full_o,  0);
    check_val("almost_empty", bus.almost_empty_o, 0);
`endif
    $display("step %0d wr=%0b rd=%0b clr=%0b rst=%0b -> count=%0d full=%0b empty=%0b rv=%0b ovf=%0b unf=%0b",
             n_step, wr, rd, clr, rst, bus.count_o, bus.full_o, bus.empty_o,
             bus.rd_valid_o, bus.overflow_o, bus.underflow_o);
    n_step++;
  endtask

  initial begin
    int wp;
    bus.wr_req_i  = 1'b0;
    bus.rd_req_i  = 1'b0;
    bus.clr_err_i = 1'b0;
    rst_i         = 1'b1;

    // Reset, then idle
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    // Fill to full, one extra write overflows
    for (int i = 0; i < 17; i++) step(1, 0, 0, 0);
    // Simultaneous at full: only the read goes
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    // Drain completely, one extra read underflows
    for (int i = 0; i < 17; i++) step(0, 1, 0, 0);
    // Simultaneous at empty: only the write goes
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    // Clear sticky errors, then clear coinciding with a new underflow
    step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    // Wrap-around: write 10, read 10, write 10
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
    // Down to 5, then simultaneous requests
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
    // Reset mid-stream with a read in flight
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // Biased random traffic: write-heavy, read-heavy, then balanced phases
    for (int i = 0; i < 400; i++) begin
      case ((i / 32) % 4)
        0:       wp = 80;
        1:       wp = 20;
        default: wp = 50;
      endcase
      step($urandom_range(99) < wp,
           $urandom_range(99) < (100 - wp),
           $urandom_range(15) == 0,
           $urandom_range(199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
